pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Registered program-counter unit for one TinyGPU core. It generalises the two-way next-PC select into a parametrised sequencer that holds the PC. It adds stall/enable gating, call/return through an internal return-address stack, halt, restart, and sticky fault reporting. It sits between the decoder/branch-resolve logic and the instruction fetch address.

Parameters:
PC_WIDTH, 8, width of PC and all target addresses
STACK_DEPTH, 4, return-address stack entries (>=1)
RESET_PC, 0, PC value after reset or Restart
PC_INC, 1, sequential increment per advance

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Restart  input  1  synchronous restart pulse; highest priority
Enable  input  1  advance request for this cycle
Stall  input  1  hold PC this cycle; overrides Enable
Halt  input  1  enter HALTED on this advance
Branch  input  1  taken branch on this advance
BranchTarget  input  PC_WIDTH  branch destination
Call  input  1  call on this advance; pushes return address
CallTarget  input  PC_WIDTH  call destination
Ret  input  1  return on this advance; pops stack
PC  output  PC_WIDTH  current registered PC
NextPC  output  PC_WIDTH  combinational value PC takes at next edge
Halted  output  1  state == HALTED
Fault  output  1  state == FAULT
StackOverflow  output  1  sticky; call attempted with stack full
StackUnderflow  output  1  sticky; return attempted with stack empty
StackCount  output  $clog2(STACK_DEPTH+1)  valid stack entries

Behaviour:
- Reset (rst_n low, asynchronous): PC=RESET_PC; state RUN; StackCount=0; StackOverflow=0; StackUnderflow=0; Halted=0; Fault=0. Stack contents don't care.
- States:
  - RUN: normal operation.
  - HALTED: PC frozen; entered via Halt.
  - FAULT: PC frozen; entered via overflow or underflow.
  - Only Restart or reset leaves HALTED or FAULT.
- Restart: at the edge, PC=RESET_PC, StackCount=0, sticky flags cleared, state RUN. Applies in any state, regardless of Stall, Enable or other inputs.
- Advance condition: state==RUN && Enable && !Stall && !Restart. With no advance, PC and stack hold.
- On advance, priority is Halt > Ret > Call > Branch > sequential. Only the highest-priority request acts:
  - Halt: PC holds; state goes to HALTED.
  - Ret, StackCount>0: PC = top entry; StackCount decrements.
  - Ret, StackCount==0: PC holds; StackUnderflow=1; state goes to FAULT.
  - Call, StackCount<STACK_DEPTH: push PC+PC_INC; PC=CallTarget; StackCount increments.
  - Call, stack full: PC holds; nothing is pushed; StackOverflow=1; state goes to FAULT.
  - Branch: PC=BranchTarget.
  - Otherwise: PC=PC+PC_INC.
- Arithmetic: PC+PC_INC is truncated to PC_WIDTH (modulo 2^PC_WIDTH). PC at 2^PC_WIDTH-1 wraps to 0. The same truncation applies to pushed return addresses.
- NextPC equals the value PC takes at the next edge, given current inputs, under all of the rules above. It equals PC whenever there is no advance.
- Latency: one cycle from request to PC update. No internal bubbles, so back-to-back advances are allowed every cycle.
- The stack is LIFO. Call immediately followed by Ret returns to the call site +PC_INC.
- Simultaneous Call and Ret: Ret wins; no push occurs.
- Reset asserted mid-operation clears everything asynchronously. The first advance after rst_n deasserts uses PC=RESET_PC.

Test Plan:
1. Reset, Enable=1 for 300 cycles (PC_WIDTH=8) -> PC counts 0,1,…,255,0,…; StackCount=0 throughout.
2. PC=0x10, Branch=1 with BranchTarget=0x40 while Stall=1 for 2 cycles, then Stall=0 -> PC stays 0x10 for 2 cycles, then 0x40. NextPC shows 0x10 while stalled and 0x40 once unstalled.
3. PC=0x05: Call to 0x20, then Call to 0x30, then Ret, then Ret -> PC sequence 0x20, 0x30, 0x21, 0x06. StackCount goes 1, 2, 1, 0.
4. STACK_DEPTH=4: five nested Calls -> 5th Call leaves PC unchanged, StackOverflow=1, Fault=1, StackCount=4. Further Enable has no effect. Restart -> PC=0, flags clear, state RUN.
5. Ret with empty stack at PC=0x08 -> PC stays 0x08, StackUnderflow=1, Fault=1.
6. Halt=1, Branch=1 and Call=1 together at PC=0x12 -> Halted=1, PC=0x12, StackCount unchanged. Assert rst_n=0 mid-cycle -> PC=0 and Halted=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer for one TinyGPU core: stall/enable gating,
// call/return through a small return-address stack, halt, restart and sticky faults.
module pc_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0,
    parameter int PC_INC      = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 Restart,
    input  logic                                 Enable,
    input  logic                                 Stall,
    input  logic                                 Halt,
    input  logic                                 Branch,
    input  logic [PC_WIDTH-1:0]                  BranchTarget,
    input  logic                                 Call,
    input  logic [PC_WIDTH-1:0]                  CallTarget,
    input  logic                                 Ret,
    output logic [PC_WIDTH-1:0]                  PC,
    output logic [PC_WIDTH-1:0]                  NextPC,
    output logic                                 Halted,
    output logic                                 Fault,
    output logic                                 StackOverflow,
    output logic                                 StackUnderflow,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     StackCount
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    // Storage is rounded up to a power of two so every index value is in range.
    localparam int SLOTS = 1 << IDX_W;

    localparam logic [PC_WIDTH-1:0] PC_START = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(PC_INC);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED,
        ST_FAULT
    } state_t;

    state_t              state, state_next;
    logic [PC_WIDTH-1:0] pc_q, pc_next, pc_plus;
    logic [CNT_W-1:0]    count_q, count_next;
    logic                overflow_q, overflow_next;
    logic                underflow_q, underflow_next;
    logic                advance, push, stack_full, stack_empty;
    logic [IDX_W-1:0]    push_idx, top_idx;
    logic [PC_WIDTH-1:0] stack_mem [SLOTS];

    assign pc_plus     = pc_q + PC_STEP;
    assign stack_full  = (count_q == CNT_FULL);
    assign stack_empty = (count_q == '0);
    assign push_idx    = IDX_W'(count_q);
    assign top_idx     = IDX_W'(count_q - CNT_ONE);
    assign advance     = (state == ST_RUN) && Enable && !Stall && !Restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            pc_q        <= PC_START;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state       <= state_next;
            pc_q        <= pc_next;
            count_q     <= count_next;
            overflow_q  <= overflow_next;
            underflow_q <= underflow_next;
        end
    end

    // Stack contents need no reset; only the count decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[push_idx] <= pc_plus;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc_q;
        count_next     = count_q;
        overflow_next  = overflow_q;
        underflow_next = underflow_q;
        push           = 1'b0;

        if (Restart) begin
            state_next     = ST_RUN;
            pc_next        = PC_START;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else if (advance) begin
            if (Halt) begin
                state_next = ST_HALTED;
            end else if (Ret) begin
                if (stack_empty) begin
                    underflow_next = 1'b1;
                    state_next     = ST_FAULT;
                end else begin
                    pc_next    = stack_mem[top_idx];
                    count_next = count_q - CNT_ONE;
                end
            end else if (Call) begin
                if (stack_full) begin
                    overflow_next = 1'b1;
                    state_next    = ST_FAULT;
                end else begin
                    push       = 1'b1;
                    pc_next    = CallTarget;
                    count_next = count_q + CNT_ONE;
                end
            end else if (Branch) begin
                pc_next = BranchTarget;
            end else begin
                pc_next = pc_plus;
            end
        end
    end

    always_comb begin
        PC             = pc_q;
        NextPC         = pc_next;
        Halted         = (state == ST_HALTED);
        Fault          = (state == ST_FAULT);
        StackOverflow  = overflow_q;
        StackUnderflow = underflow_q;
        StackCount     = count_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts every
// cycle's PC/flags; a monitor process pops predictions and compares against the DUT.
module tb_pc_sequencer;

    localparam int PC_WIDTH    = 8;
    localparam int STACK_DEPTH = 4;
    localparam int RESET_PC    = 0;
    localparam int PC_INC      = 1;
    localparam int CNT_W       = $clog2(STACK_DEPTH + 1);
    localparam int PC_MOD      = 1 << PC_WIDTH;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                Restart = 1'b0, Enable = 1'b0, Stall = 1'b0, Halt = 1'b0;
    logic                Branch = 1'b0, Call = 1'b0, Ret = 1'b0;
    logic [PC_WIDTH-1:0] BranchTarget = '0, CallTarget = '0;
    logic [PC_WIDTH-1:0] PC, NextPC;
    logic                Halted, Fault, StackOverflow, StackUnderflow;
    logic [CNT_W-1:0]    StackCount;

    pc_sequencer #(
        .PC_WIDTH(PC_WIDTH), .STACK_DEPTH(STACK_DEPTH), .RESET_PC(RESET_PC), .PC_INC(PC_INC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .Restart(Restart), .Enable(Enable), .Stall(Stall),
        .Halt(Halt), .Branch(Branch), .BranchTarget(BranchTarget), .Call(Call),
        .CallTarget(CallTarget), .Ret(Ret), .PC(PC), .NextPC(NextPC), .Halted(Halted),
        .Fault(Fault), .StackOverflow(StackOverflow), .StackUnderflow(StackUnderflow),
        .StackCount(StackCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                restart, enable, stall, halt, branch;
        logic [PC_WIDTH-1:0] btgt;
        logic                call;
        logic [PC_WIDTH-1:0] ctgt;
        logic                ret;
    } stim_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                halted, fault, ovf, unf;
        logic [CNT_W-1:0]    count;
    } expect_t;

    expect_t sb[$];
    int      checks = 0;
    int      fails  = 0;

    // Reference model: state 0=running, 1=halted, 2=faulted; stack is a plain queue.
    int m_pc;
    int m_stack[$];
    int m_state;
    bit m_ovf, m_unf;

    function automatic void model_reset();
        m_pc    = RESET_PC % PC_MOD;
        m_stack.delete();
        m_state = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endfunction

    function automatic void model_step(stim_t s);
        if (s.restart) begin
            model_reset();
        end else if (m_state == 0 && s.enable && !s.stall) begin
            if (s.halt) begin
                m_state = 1;
            end else if (s.ret) begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                end else begin
                    m_unf   = 1'b1;
                    m_state = 2;
                end
            end else if (s.call) begin
                if (m_stack.size() < STACK_DEPTH) begin
                    m_stack.push_back((m_pc + PC_INC) % PC_MOD);
                    m_pc = int'(s.ctgt);
                end else begin
                    m_ovf   = 1'b1;
                    m_state = 2;
                end
            end else if (s.branch) begin
                m_pc = int'(s.btgt);
            end else begin
                m_pc = (m_pc + PC_INC) % PC_MOD;
            end
        end
    endfunction

    function automatic expect_t model_expect();
        expect_t e;
        e.pc     = PC_WIDTH'(m_pc);
        e.halted = (m_state == 1);
        e.fault  = (m_state == 2);
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        e.count  = CNT_W'(m_stack.size());
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input stim_t s);
        @(negedge clk);
        Restart      = s.restart;
        Enable       = s.enable;
        Stall        = s.stall;
        Halt         = s.halt;
        Branch       = s.branch;
        BranchTarget = s.btgt;
        Call         = s.call;
        CallTarget   = s.ctgt;
        Ret          = s.ret;
        model_step(s);
        sb.push_back(model_expect());
    endtask

    task automatic op_idle();
        stim_t s = '0;
        apply_stimulus(s);
    endtask

    task automatic op_adv();
        stim_t s = '0;
        s.enable = 1'b1;
        apply_stimulus(s);
    endtask

    task automatic op_branch(input logic [PC_WIDTH-1:0] t, input logic stall);
        stim_t s = '0;
        s.enable = 1'b1; s.branch = 1'b1; s.btgt = t; s.stall = stall;
        apply_stimulus(s);
    endtask

    task automatic op_call(input logic [PC_WIDTH-1:0] t);
        stim_t s = '0;
        s.enable = 1'b1; s.call = 1'b1; s.ctgt = t;
        apply_stimulus(s);
    endtask

    task automatic op_ret();
        stim_t s = '0;
        s.enable = 1'b1; s.ret = 1'b1;
        apply_stimulus(s);
    endtask

    task automatic op_restart();
        stim_t s = '0;
        s.restart = 1'b1; s.enable = 1'b1; s.stall = 1'b1; s.branch = 1'b1; s.btgt = 8'hAA;
        apply_stimulus(s);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, ".PC"}, 32'(PC), 32'(RESET_PC));
        check_output({tag, ".NextPC"}, 32'(NextPC), 32'(RESET_PC));
        check_output({tag, ".Halted"}, 32'(Halted), 32'd0);
        check_output({tag, ".Fault"}, 32'(Fault), 32'd0);
        check_output({tag, ".Overflow"}, 32'(StackOverflow), 32'd0);
        check_output({tag, ".Underflow"}, 32'(StackUnderflow), 32'd0);
        check_output({tag, ".StackCount"}, 32'(StackCount), 32'd0);
    endtask

    // Monitor: NextPC is sampled late in the low phase, registered outputs just after the edge.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output("NextPC", 32'(NextPC), 32'(e.pc));
                @(posedge clk);
                #1;
                check_output("PC", 32'(PC), 32'(e.pc));
                check_output("Halted", 32'(Halted), 32'(e.halted));
                check_output("Fault", 32'(Fault), 32'(e.fault));
                check_output("StackOverflow", 32'(StackOverflow), 32'(e.ovf));
                check_output("StackUnderflow", 32'(StackUnderflow), 32'(e.unf));
                check_output("StackCount", 32'(StackCount), 32'(e.count));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        model_reset();
        #3;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] free-running count with wrap");
        for (int i = 0; i < 300; i++) op_adv();

        $display("[TB] stalled branch");
        op_branch(8'h10, 1'b0);
        op_branch(8'h40, 1'b1);
        op_branch(8'h40, 1'b1);
        op_branch(8'h40, 1'b0);

        $display("[TB] nested call and return");
        op_branch(8'h05, 1'b0);
        op_call(8'h20);
        op_call(8'h30);
        op_ret();
        op_ret();

        $display("[TB] stack overflow");
        for (int i = 0; i < 5; i++) op_call(PC_WIDTH'(8'h50 + i));
        for (int i = 0; i < 3; i++) op_adv();
        op_restart();
        op_adv();

        $display("[TB] stack underflow");
        op_branch(8'h08, 1'b0);
        op_ret();
        op_adv();
        op_restart();

        $display("[TB] simultaneous call and ret");
        op_call(8'h60);
        s = '0; s.enable = 1'b1; s.call = 1'b1; s.ctgt = 8'h70; s.ret = 1'b1;
        apply_stimulus(s);

        $display("[TB] halt with branch and call, then async reset");
        op_branch(8'h12, 1'b0);
        s = '0; s.enable = 1'b1; s.halt = 1'b1; s.branch = 1'b1; s.btgt = 8'h33;
        s.call = 1'b1; s.ctgt = 8'h44;
        apply_stimulus(s);
        op_adv();
        op_idle();
        wait_drain();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        op_adv();
        op_adv();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            s         = '0;
            s.restart = ($urandom_range(0, 24) == 0);
            s.enable  = ($urandom_range(0, 3) != 0);
            s.stall   = ($urandom_range(0, 4) == 0);
            s.halt    = ($urandom_range(0, 49) == 0);
            s.ret     = ($urandom_range(0, 4) == 0);
            s.call    = ($urandom_range(0, 3) == 0);
            s.branch  = ($urandom_range(0, 3) == 0);
            s.btgt    = PC_WIDTH'($urandom);
            s.ctgt    = PC_WIDTH'($urandom);
            apply_stimulus(s);
        end

        op_idle();
        wait_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
